// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// default geometry and the address range test used on request acceptance.
package mem_pkg;

  localparam int DEPTH_DEFAULT  = 32;
  localparam int RAM_AW_DEFAULT = 5;
  localparam int REQ_AW         = 8;
  localparam int DATA_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } mem_state_e;

  // An address is serviceable only when it names one of the DEPTH real words.
  function automatic logic addr_in_range(input logic [REQ_AW-1:0] addr,
                                         input int depth);
    return ({{(32-REQ_AW){1'b0}}, addr} < depth[31:0]);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: accepts one request, performs a
// one-cycle RAM access (skipped for out-of-range addresses) and holds the response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int RAM_AW = RAM_AW_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; a response transfers on a rising edge where
  // resp_valid and resp_ready are both 1. Neither side may retract a
  // presented item before its transfer edge; the controller holds
  // resp_data/resp_error stable while resp_valid is 1.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_address,
  input  logic [31:0]       req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_error,
  output logic [RAM_AW-1:0] ram_address,
  output logic [31:0]       ram_data_out,
  input  logic [31:0]       ram_data_in,
  output logic              ram_we,
  output logic              ram_chip_select,
  output logic [1:0]        state_dbg
);

  mem_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_error_q, resp_error_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    addr_d          = addr_q;
    data_d          = data_q;
    resp_data_d     = resp_data_q;
    resp_error_d    = resp_error_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    ram_chip_select = 1'b0;
    ram_we          = 1'b0;
    ram_address     = '0;
    ram_data_out    = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_address[RAM_AW-1:0];
          data_d  = req_data;
          if (addr_in_range(req_address, DEPTH)) begin
            state_d = ST_ACCESS;
          end else begin
            // Out-of-range requests never touch the RAM and answer a cycle early.
            state_d      = ST_RESPOND;
            resp_error_d = 1'b1;
            resp_data_d  = '0;
          end
        end
      end

      ST_ACCESS: begin
        ram_chip_select = 1'b1;
        ram_we          = write_q;
        ram_address     = addr_q;
        ram_data_out    = data_q;
        state_d         = ST_RESPOND;
        resp_error_d    = 1'b0;
        resp_data_d     = write_q ? 32'd0 : ram_data_in;
      end

      ST_RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: external RAM model, table vectors, reset and
// back-to-back corner sequences, and randomized traffic against a word-array model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int DEPTH  = 32;
  localparam int RAM_AW = 5;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [7:0]        req_address;
  logic [31:0]       req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_error;
  logic [RAM_AW-1:0] ram_address;
  logic [31:0]       ram_data_out;
  logic [31:0]       ram_data_in;
  logic              ram_we;
  logic              ram_chip_select;
  logic [1:0]        state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  mem_access_ctrl #(.DEPTH(DEPTH), .RAM_AW(RAM_AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_chip_select(ram_chip_select), .state_dbg(state_dbg)
  );

  // External RAM: synchronous write, combinational read.
  logic [31:0] ram_mem [0:DEPTH-1] = '{default: 32'h0};
  always @(posedge clock) begin
    if (ram_chip_select && ram_we) ram_mem[ram_address] <= ram_data_out;
  end
  assign ram_data_in = ram_mem[ram_address];

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_q [$];

  task automatic model_apply(input logic w, input logic [7:0] a, input logic [31:0] d,
                             output logic e_err, output logic [31:0] e_data,
                             output int e_lat, output int e_cs);
    if (int'(a) >= DEPTH) begin
      e_err = 1'b1; e_data = 32'd0; e_lat = 1; e_cs = 0;
    end else begin
      e_err = 1'b0; e_lat = 2; e_cs = 1;
      e_data = w ? 32'd0 : model_mem[a];
      if (w) model_mem[a] = d;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd, output logic re,
                         output int lat, output int cs_n);
    logic [31:0] held;
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0; cs_n = 0; rd = '0; re = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (ram_chip_select) begin
        cs_n++;
        chk("ram_addr", 32'(ram_address), 32'(a[4:0]));
        chk("ram_we", 32'(ram_we), 32'(w));
        if (w) chk("ram_wdata", ram_data_out, d);
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
      chk("busy_ready", 32'(req_ready), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: got no resp_valid expected within 8 cycles");
      return;
    end
    held = resp_data;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_address = 8'($urandom_range(0, 31));
      @(posedge clock);
      @(negedge clock);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, held);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_cs", 32'(ram_chip_select), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    rd = resp_data; re = resp_error;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    chk("after_valid", 32'(resp_valid), 32'd0);
    chk("after_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic model_txn(input string tag, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input int hold);
    logic [31:0] rd, e_data;
    logic re, e_err;
    int lat, cs_n, e_lat, e_cs;
    model_apply(w, a, d, e_err, e_data, e_lat, e_cs);
    exp_q.push_back(e_data);
    run_txn(w, a, d, hold, rd, re, lat, cs_n);
    chk({tag, "_data"}, rd, exp_q.pop_front());
    chk({tag, "_err"}, 32'(re), 32'(e_err));
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_cs"}, 32'(cs_n), 32'(e_cs));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_cs"}, 32'(ram_chip_select), 32'd0);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_address), 32'd0);
    chk({tag, "_ram_wdata"}, ram_data_out, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd, e_data;
    logic re, e_err;
    int lat, cs_n, e_lat, e_cs, acc, css, rvs;

    vecs[0]  = '{1'b1, 8'd3,   32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 2};
    vecs[1]  = '{1'b0, 8'd3,   32'h0,         0, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[2]  = '{1'b0, 8'd40,  32'h0,         0, 1'b1, 32'h0000_0000, 1};
    vecs[3]  = '{1'b1, 8'd31,  32'hA5A5_0031, 0, 1'b0, 32'h0000_0000, 2};
    vecs[4]  = '{1'b0, 8'd31,  32'h0,         1, 1'b0, 32'hA5A5_0031, 2};
    vecs[5]  = '{1'b1, 8'd32,  32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1};
    vecs[6]  = '{1'b0, 8'd32,  32'h0,         2, 1'b1, 32'h0000_0000, 1};
    vecs[7]  = '{1'b0, 8'd3,   32'h0,         5, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[8]  = '{1'b0, 8'd255, 32'h0,         0, 1'b1, 32'h0000_0000, 1};
    vecs[9]  = '{1'b0, 8'd0,   32'h0,         0, 1'b0, 32'hC0DE_0000, 2};
    vecs[10] = '{1'b1, 8'd0,   32'h0BAD_F00D, 2, 1'b0, 32'h0000_0000, 2};
    vecs[11] = '{1'b0, 8'd0,   32'h0,         0, 1'b0, 32'h0BAD_F00D, 2};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_address = '0; req_data = '0; resp_ready = 1'b0;

    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      model_txn($sformatf("preload%0d", i), 1'b1, 8'(i), 32'hC0DE_0000 + 32'(i), 0);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold, rd, re, lat, cs_n);
      model_apply(vecs[i].w, vecs[i].a, vecs[i].d, e_err, e_data, e_lat, e_cs);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_cs", i), 32'(cs_n), vecs[i].exp_err ? 32'd0 : 32'd1);
    end

    // Reset pulse in the middle of a write access.
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'd7; req_data = 32'h0000_1234;
    @(posedge clock);
    #2;
    req_valid = 1'b0;
    chk("midreset_cs_before", 32'(ram_chip_select), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clock);
    @(negedge clock);
    chk("midreset_ram7", ram_mem[7], model_mem[7]);
    reset_n = 1'b1;
    model_txn("midreset_read7", 1'b0, 8'd7, 32'h0, 0);

    // req_valid held high with responses consumed immediately.
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'd5; resp_ready = 1'b1;
    acc = 0; css = 0; rvs = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) acc++;
      if (ram_chip_select) css++;
      if (resp_valid) begin
        rvs++;
        chk("stream_data", resp_data, model_mem[5]);
      end
      @(posedge clock);
      @(negedge clock);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd4);
    chk("stream_selects", 32'(css), 32'd4);
    chk("stream_resps", 32'(rvs), 32'd4);
    chk("stream_idle", 32'(req_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255))
                                       : 8'($urandom_range(0, 33));
      model_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra,
                $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
